// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder slice.
//   sa_state_t   : controller state (IDLE, SHIFT, DONE)
//   SA_WIDTH_DEF : default operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sa_state_t;

    localparam int SA_WIDTH_DEF = 8;

endpackage

// File: rtl/full_adder_st.sv
// full_adder_st
// Single-bit full adder built from two half adders and an OR of their carries.
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   carry     : majority(a, b, cin)
module full_adder_st (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic s0;
    logic c0;
    logic c1;

    half_adder_st u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s0),
        .carry (c0)
    );

    half_adder_st u_ha1 (
        .a     (s0),
        .b     (cin),
        .sum   (sum),
        .carry (c1)
    );

    // The two half-adder carries can never both be 1, so OR suffices.
    assign carry = c0 | c1;

endmodule

// File: rtl/half_adder_st.sv
// half_adder_st
// Single-bit half adder cell.
//   a, b  : input bits
//   sum   : a XOR b
//   carry : a AND b
module half_adder_st (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder: accepts two WIDTH-bit operands plus carry-in, adds them one
// bit per clock LSB first through a single full-adder cell, and returns the
// WIDTH-bit sum and carry-out on an output handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    sa_state_t        state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             c_q;
    logic [CW-1:0]    count;
    logic             fa_s;
    logic             fa_c;

    full_adder_st u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (c_q),
        .sum   (fa_s),
        .carry (fa_c)
    );

    // Controller and datapath registers. Sum bits enter at the MSB so that after
    // WIDTH shifts the first (LSB) result bit has reached bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c_q   <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        c_q   <= cin;
                        count <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
                    c_q   <= fa_c;
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags depend on the state register alone.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = s_sr;
    assign cout      = c_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder: accepts two WIDTH-bit operands and a carry-in on a valid/ready handshake, then adds them one bit per clock, LSB first. Each bit goes through a single full-adder cell, built from two `half_adder_st` instances and an OR gate, with the carry held in a flip-flop. The registered WIDTH-bit sum and carry-out are returned on a second valid/ready handshake. It is the sequential stage that consumes the half-adder cell's sum/carry outputs and trades area for latency against a ripple-carry adder.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Legal range is WIDTH ≥ 2.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  operands valid.
- `in_ready`  output  1  block can accept operands.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry-in.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts result.
- `sum`  output  WIDTH  registered sum.
- `cout`  output  1  registered carry-out.

## Operation
- Registers:
  - operand shift registers `a_sr`, `b_sr` (WIDTH each);
  - sum shift register `s_sr` (WIDTH);
  - carry flop `c_q`;
  - bit counter, $clog2(WIDTH) bits;
  - state.
- FSM states are IDLE, SHIFT and DONE.
- **IDLE**
  - `in_ready` = 1, `out_valid` = 0.
  - On `in_valid` && `in_ready`: `a_sr`←`a`, `b_sr`←`b`, `c_q`←`cin`, counter←0, `s_sr` unchanged; go to SHIFT.
- **SHIFT**
  - Each cycle, a full-add is formed from `a_sr[0]`, `b_sr[0]` and `c_q`, producing fa_s and fa_c.
  - `s_sr`←{fa_s, `s_sr`[WIDTH-1:1]}; `c_q`←fa_c; `a_sr` and `b_sr` shift right with zero fill; counter increments.
  - When counter == WIDTH-1, that update is the last one; go to DONE.
  - `in_ready` = 0, `out_valid` = 0.
- **DONE**
  - `out_valid` = 1, `sum` = `s_sr`, `cout` = `c_q`.
  - On `out_ready`, go to IDLE.
  - `in_ready` = 0: there is no overlap of accept and deliver.
- Arithmetic: {`cout`, `sum`} = `a` + `b` + `cin`, computed mod 2^(WIDTH+1), so the result is exact.
- `in_ready` and `out_valid` are decoded combinationally from the state register only, never from the inputs.
- `in_valid` while not in IDLE is ignored; operands are not latched.
- `sum`/`cout` stay stable whenever `out_valid`=1 && `out_ready`=0.
- `out_ready` outside DONE is ignored.
- After a DONE→IDLE handshake, `sum`/`cout` keep their last value until the next SHIFT begins; the value is then don't-care while `out_valid`=0.
- Reset (asserted at any time, including mid-SHIFT or in DONE):
  - state→IDLE immediately; all registers→0;
  - outputs become `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0;
  - an in-flight operation is discarded and no partial result is ever presented.

## Timing
- Accept edge T (IDLE, `in_valid`=1): SHIFT occupies edges T+1 … T+WIDTH.
- `out_valid` rises after edge T+WIDTH, giving a latency of WIDTH cycles from the accept edge.
- The earliest output handshake is edge T+WIDTH+1, so the earliest next accept is edge T+WIDTH+2. Peak throughput is one add per WIDTH+2 cycles.
- Back-pressure extends DONE by exactly the number of cycles `out_ready` is low.
- Reset deassertion has no synchronizer requirement inside the block; the first accept is possible on the first edge after `rst_n` rises.

## Structure
- Package `serial_adder_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t`;
  - the default-width constant `SA_WIDTH_DEF` = 8.
- One sub-module, `full_adder_st` (inputs a, b, cin; outputs sum, carry):
  - built from two `half_adder_st` instances plus an OR of their carries;
  - purely combinational, instantiated once in the datapath.
- Top level contains the FSM, counter, shift registers and output decode.

## Test plan
- Reset then WIDTH=8, a=0x00, b=0x00, cin=0 → `out_valid` after 8 cycles, `sum`=0x00, `cout`=0.
- a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1. a=0xA5, b=0x5A, cin=1 → `sum`=0x00, `cout`=1.
- Back-pressure:
  - stimulus: a=0x3C, b=0x0F, cin=0, with `out_ready` held low 5 cycles in DONE;
  - response: `sum`=0x4B, `cout`=0, stable all 5 cycles;
  - `in_ready`=0 throughout, and an `in_valid` pulse with a=0x11 during SHIFT and DONE is ignored.
- Reset mid-operation:
  - stimulus: `rst_n` pulsed low at SHIFT bit 3;
  - response: immediate `out_valid`=0, `sum`=0, `in_ready`=1;
  - follow-up: next op a=0x80, b=0x80, cin=0 → `sum`=0x00, `cout`=1.
- Exhaustive with WIDTH=4:
  - stimulus: all 512 (a, b, cin) combos, back-to-back with `out_ready`=1;
  - response: every result matches a+b+cin;
  - spacing: successive accepts are exactly 6 cycles apart.
